axis_fifo_param: RTL

Parametrised AXI-Stream-style synchronous FIFO that supersedes the fixed 2048/4096-entry byte FIFOs. It is generic in data width and depth, stores `last` alongside each data word, and reports occupancy with almost-full and almost-empty flags. An optional packet (store-and-forward) mode withholds output until a complete packet is buffered. It sits between any streaming producer and consumer in the datapath.

---
 rtl/axis_fifo_pkg.sv | 23 ++
 rtl/axis_fifo_param_ram.sv | 28 ++
 rtl/axis_fifo_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the parametrised AXI-Stream FIFO: release-state encoding,
// pointer width and wrap-aware occupancy arithmetic.
package axis_fifo_pkg;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RELEASE = 1'b1
   } rel_state_t;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // Pointers carry one extra wrap bit, so the difference is taken modulo 2^(ptr_w+1).
   function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                            input logic [31:0] rd,
                                            input int          ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << (ptr_w + 1)) - 32'd1;
      return (wr - rd) & mask;
   endfunction

endpackage

// File: rtl/axis_fifo_param_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram
   import axis_fifo_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   localparam int ADDR_W = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo_param.sv
// Parametrised first-word-fall-through AXI-Stream FIFO with level flags,
// packet counting and optional store-and-forward with oversize cut-through.
module axis_fifo_param
   import axis_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 2048,
   parameter int AF_LEVEL    = DEPTH - 4,
   parameter int AE_LEVEL    = 4,
   parameter int PACKET_MODE = 0,
   localparam int PTR_W      = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [PTR_W:0]        count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_W:0]        pkt_count,
   output logic                  oversize
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE     = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
   localparam logic             PKT_EN  = (PACKET_MODE != 0);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   logic [CNT_W-1:0] wr_ptr_r;
   logic [CNT_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] pkt_count_r;
   rel_state_t       state_r;
   rel_state_t       state_next_s;
   logic             oversize_r;
   logic             oversize_next_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic             pkt_inc_s;
   logic             pkt_dec_s;
   beat_t            wr_beat_s;
   beat_t            rd_beat_s;

   assign count        = CNT_W'(ptr_diff(32'(wr_ptr_r), 32'(rd_ptr_r), PTR_W));
   assign full         = (count == DEPTH_C);
   assign empty        = (wr_ptr_r == rd_ptr_r);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);
   assign s_ready      = !full;
   assign pkt_count    = pkt_count_r;
   assign oversize     = oversize_r;

   // Head-beat qualification; packet mode also gates on a whole packet or active release
   always_comb begin
      m_valid = 1'b0;
      if (PKT_EN) begin
         m_valid = !empty && ((pkt_count_r != ZERO) || (state_r == ST_RELEASE));
      end else begin
         m_valid = !empty;
      end
   end

   assign wr_en_s   = s_valid && !full;
   assign rd_en_s   = m_valid && m_ready;
   assign pkt_inc_s = wr_en_s && s_last;
   assign pkt_dec_s = rd_en_s && m_last;

   assign wr_beat_s = '{last: s_last, data: s_data};
   assign m_data    = rd_beat_s.data;
   assign m_last    = rd_beat_s.last;

   fifo_ram #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en_s),
      .waddr (wr_ptr_r[PTR_W-1:0]),
      .wdata (wr_beat_s),
      .raddr (rd_ptr_r[PTR_W-1:0]),
      .rdata (rd_beat_s)
   );

   // Release FSM: a full FIFO holding no complete packet must cut through or it deadlocks
   always_comb begin
      state_next_s    = state_r;
      oversize_next_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (PKT_EN && full && (pkt_count_r == ZERO)) begin
               state_next_s    = ST_RELEASE;
               oversize_next_s = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            if (pkt_dec_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RELEASE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Pointers, packet counter and release state
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r    <= ZERO;
         rd_ptr_r    <= ZERO;
         pkt_count_r <= ZERO;
         state_r     <= ST_IDLE;
         oversize_r  <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + ONE;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + ONE;
         end
         case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_count_r <= pkt_count_r + ONE;
            2'b01:   pkt_count_r <= pkt_count_r - ONE;
            default: pkt_count_r <= pkt_count_r;
         endcase
         state_r    <= state_next_s;
         oversize_r <= oversize_next_s;
      end
   end

endmodule
